la_isoctrl: RTL and testbench

//  Power-domain sequencer for one switchable domain. Drives the iso pins of
//  the la_isohi/la_isolo cells on the domain boundary, the domain power-switch

---
 rtl/la_isoctrl.sv | 100 ++++++++++
 tb/tb_la_isoctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/la_isoctrl.sv
// Power-domain sequencer: orders isolation, power-switch enable and domain reset
// for one switchable domain, with an ack timeout and a sticky error flag.
module la_isoctrl #(
    parameter string PROP    = "DEFAULT",
    parameter int    ISOWAIT = 4,
    parameter int    TIMEOUT = 255,
    parameter int    CW      = 8
) (
    input  logic clk,
    input  logic nreset,
    input  logic req_off,
    input  logic pwr_ack,
    output logic iso,
    output logic pd_nreset,
    output logic pwr_en,
    output logic on,
    output logic busy,
    output logic err
);

    if (PROP == "" || ISOWAIT < 1 || TIMEOUT < 1 ||
        (1 << CW) <= ISOWAIT || (1 << CW) <= TIMEOUT) begin : g_bad_cfg
        $error("la_isoctrl %s: counter too narrow or zero wait", PROP);
    end

    typedef enum logic [2:0] {
        S_OFF, S_PWRUP, S_RELRST, S_ON, S_ISO, S_ASRST, S_PWROFF
    } state_t;

    localparam logic [CW-1:0] ISO_LAST = CW'(ISOWAIT - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          err_d;

    // Next-state: req_off is only looked at in ON and OFF, so no aborts.
    always_comb begin
        state_d = state_q;
        err_d   = err;
        case (state_q)
            S_OFF: begin
                if (req_off)   err_d   = 1'b0;
                else if (!err) state_d = S_PWRUP;
            end
            S_PWRUP: begin
                if (pwr_ack) begin
                    state_d = S_RELRST;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_OFF;
                end
            end
            S_RELRST: if (cnt_q == ISO_LAST) state_d = S_ON;
            S_ON:     if (req_off)           state_d = S_ISO;
            S_ISO:    if (cnt_q == ISO_LAST) state_d = S_ASRST;
            S_ASRST:  if (cnt_q == ISO_LAST) state_d = S_PWROFF;
            S_PWROFF: begin
                if (!pwr_ack) begin
                    state_d = S_OFF;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_OFF;
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
        end
    end

    // Outputs registered from the next state so they change on the same edge
    // as the state and are clamped to OFF values the instant nreset falls.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            iso       <= 1'b1;
            pd_nreset <= 1'b0;
            pwr_en    <= 1'b0;
            on        <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            iso       <= (state_d != S_ON);
            pd_nreset <= (state_d == S_RELRST) || (state_d == S_ON) || (state_d == S_ISO);
            pwr_en    <= (state_d != S_OFF) && (state_d != S_PWROFF);
            on        <= (state_d == S_ON);
            busy      <= (state_d != S_ON) && (state_d != S_OFF);
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_la_isoctrl.sv
// Directed bench for la_isoctrl with ISOWAIT=4, TIMEOUT=8; outputs are checked
// as the vector {iso, pd_nreset, pwr_en, on, busy, err}.
module tb_la_isoctrl;

    logic clk;
    logic nreset;
    logic req_off;
    logic pwr_ack;
    logic iso, pd_nreset, pwr_en, on, busy, err;

    int checks = 0;
    int fails  = 0;

    localparam logic [5:0] V_OFF    = 6'b100000;
    localparam logic [5:0] V_OFFERR = 6'b100001;
    localparam logic [5:0] V_PWRUP  = 6'b101010;
    localparam logic [5:0] V_RELRST = 6'b111010;
    localparam logic [5:0] V_ON     = 6'b011100;
    localparam logic [5:0] V_ISO    = 6'b111010;
    localparam logic [5:0] V_ASRST  = 6'b101010;
    localparam logic [5:0] V_PWROFF = 6'b100010;

    la_isoctrl #(
        .PROP   ("DEFAULT"),
        .ISOWAIT(4),
        .TIMEOUT(8),
        .CW     (4)
    ) dut (
        .clk      (clk),
        .nreset   (nreset),
        .req_off  (req_off),
        .pwr_ack  (pwr_ack),
        .iso      (iso),
        .pd_nreset(pd_nreset),
        .pwr_en   (pwr_en),
        .on       (on),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100us");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {iso, pd_nreset, pwr_en, on, busy, err};
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b (iso,pdn,pen,on,busy,err)", tag, obs, exp);
        end
    endtask

    initial begin
        nreset  = 1'b1;
        req_off = 1'b1;
        pwr_ack = 1'b0;
        #2 nreset = 1'b0;
        step(2);
        chk("reset", V_OFF);
        #2 nreset = 1'b1;
        step(1);
        chk("off_hold", V_OFF);

        // Power-up; req_off pulses during RELRST and must be ignored.
        req_off = 1'b0;
        step(1);
        chk("pwrup_e0", V_PWRUP);
        step(2);
        chk("pwrup_e2", V_PWRUP);
        pwr_ack = 1'b1;
        step(1);
        chk("relrst_e3", V_RELRST);
        req_off = 1'b1;
        step(2);
        chk("relrst_e5", V_RELRST);
        req_off = 1'b0;
        step(1);
        chk("relrst_e6", V_RELRST);
        step(1);
        chk("on_e7", V_ON);
        step(2);
        chk("on_stay", V_ON);

        // Power-down; req_off drops during ISO and must be ignored.
        req_off = 1'b1;
        step(1);
        chk("iso_e0", V_ISO);
        req_off = 1'b0;
        step(2);
        chk("iso_e2", V_ISO);
        req_off = 1'b1;
        step(1);
        chk("iso_e3", V_ISO);
        step(1);
        chk("asrst_e4", V_ASRST);
        step(3);
        chk("asrst_e7", V_ASRST);
        step(1);
        chk("pwroff_e8", V_PWROFF);
        pwr_ack = 1'b0;
        step(1);
        chk("off_e9", V_OFF);
        step(1);
        chk("off_stay", V_OFF);

        // Power-up timeout with ack held low.
        req_off = 1'b0;
        step(1);
        chk("to_e0", V_PWRUP);
        step(7);
        chk("to_e7", V_PWRUP);
        step(1);
        chk("to_e8_err", V_OFFERR);
        step(2);
        chk("to_noretry", V_OFFERR);
        req_off = 1'b1;
        step(1);
        chk("err_clear", V_OFF);
        req_off = 1'b0;
        step(1);
        chk("retry", V_PWRUP);
        pwr_ack = 1'b1;
        step(1);
        chk("retry_relrst", V_RELRST);
        step(4);
        chk("retry_on", V_ON);

        // Async reset between edges clamps outputs before any clock.
        #2 nreset = 1'b0;
        #1;
        chk("async_rst", V_OFF);
        #2 nreset = 1'b1;
        req_off = 1'b1;
        pwr_ack = 1'b0;
        step(1);
        chk("post_rst", V_OFF);

        // Power-off timeout with ack stuck high.
        req_off = 1'b0;
        pwr_ack = 1'b1;
        step(1);
        chk("p2_pwrup", V_PWRUP);
        step(5);
        chk("p2_on", V_ON);
        req_off = 1'b1;
        step(9);
        chk("p2_pwroff", V_PWROFF);
        step(7);
        chk("p2_pwroff_e7", V_PWROFF);
        step(1);
        chk("p2_to_err", V_OFFERR);
        step(1);
        chk("p2_err_clr", V_OFF);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
